// File: rtl/fp_div.sv
// fp_div: FP16 (1/5/10) divider, c = a / b.
//
// Iterative radix-2 restoring division of the 11-bit significands, one
// operation in flight. Results are truncated (round toward zero) and
// underflow flushes to +0; no subnormals are produced. Inputs are not
// decoded for NaN/Inf: exponent 31 is an ordinary binade and only the
// all-zero word counts as zero (16'h8000 is a normal operand).
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   in_valid   operands a/b valid
//   in_ready   divider can accept operands (IDLE only)
//   a, b       dividend / divisor, FP16
//   out_valid  quotient c valid (DONE only)
//   out_ready  consumer accepts c
//   c          quotient, FP16
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. a/b are sampled only on the accept edge. Once out_valid is high,
// c and out_valid hold until out_ready is sampled high. in_valid is ignored
// while busy or holding a result.
//
// Timing: accept on edge N, 12 quotient-bit edges (N+1..N+12), result
// assembly on edge N+13, so out_valid rises after edge N+13.

module fp_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c
);

  localparam int unsigned ITER = 12;
  localparam logic signed [6:0] BIAS = 7'sd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [11:0]        r_q, r_d;
  logic [11:0]        q_q, q_d;
  logic [10:0]        mb_q, mb_d;
  logic signed [6:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic               a_zero_q, a_zero_d;
  logic               b_zero_q, b_zero_d;
  logic [15:0]        c_q, c_d;

  // Datapath temporaries.
  logic               q_bit;
  logic [11:0]        r_sub;
  logic signed [6:0]  exp_n;
  logic [9:0]         mant_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= 4'd0;
      r_q      <= 12'd0;
      q_q      <= 12'd0;
      mb_q     <= 11'd0;
      exp_q    <= 7'sd0;
      sign_q   <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      c_q      <= 16'h0000;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      r_q      <= r_d;
      q_q      <= q_d;
      mb_q     <= mb_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
      c_q      <= c_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    r_d      = r_q;
    q_d      = q_q;
    mb_d     = mb_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;
    c_d      = c_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    // Restoring step: remainder stays below 2*mb, so 12 bits suffice.
    q_bit = (r_q >= {1'b0, mb_q});
    r_sub = q_bit ? (r_q - {1'b0, mb_q}) : r_q;

    // Normalisation: quotient of two [1,2) significands lies in (0.5,2).
    exp_n  = q_q[11] ? exp_q : (exp_q - 7'sd1);
    mant_n = q_q[11] ? q_q[10:1] : q_q[9:0];

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          r_d      = {1'b0, 1'b1, a[9:0]};
          mb_d     = {1'b1, b[9:0]};
          q_d      = 12'd0;
          count_d  = 4'd0;
          sign_d   = a[15] ^ b[15];
          exp_d    = $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]}) + BIAS;
          a_zero_d = (a == 16'h0000);
          b_zero_d = (b == 16'h0000);
          state_d  = S_BUSY;
        end
      end

      S_BUSY: begin
        if (count_q < 4'(ITER)) begin
          r_d     = {r_sub[10:0], 1'b0};
          q_d     = {q_q[10:0], q_bit};
          count_d = count_q + 4'd1;
        end else begin
          // Special-case priority: zero dividend, zero divisor, overflow, underflow.
          if (a_zero_q)
            c_d = 16'h0000;
          else if (b_zero_q)
            c_d = {sign_q, 5'h1F, 10'h000};
          else if (exp_n >= 7'sd31)
            c_d = {sign_q, 5'h1F, 10'h000};
          else if (exp_n <= 7'sd0)
            c_d = 16'h0000;
          else
            c_d = {sign_q, exp_n[4:0], mant_n};
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign c = c_q;

endmodule

// File: tb/tb_fp_div.sv
// Testbench for fp_div: directed vectors with hand-computed quotients.
// The driver pushes each expected result into exp_q on issue; an independent
// monitor pops and compares whenever a result is handed off.

module tb_fp_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c;

  logic [15:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  fp_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {16'h0, c}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("result_c", {16'h0, c}, {16'h0, e});
      end
    end
  end

  // Driver tasks. All are entered and left #1 after a rising edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] ev, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("send_wait_in_ready", 32'd0, 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    if (push) exp_q.push_back(ev);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom_range(0, 16'hFFFF));
    b = 16'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  // Counts edges from accept to out_valid; in_ready must stay low meanwhile.
  task automatic measure_latency(input string name);
    int k;
    int ready_seen;
    k = 0;
    ready_seen = 0;
    while (!out_valid && k < 40) begin
      if (in_ready) ready_seen++;
      @(posedge clk); #1;
      k++;
    end
    check({name, "_latency"}, k, 32'd13);
    check({name, "_in_ready_low"}, ready_seen, 32'd0);
  endtask

  typedef struct {
    logic [15:0] av;
    logic [15:0] bv;
    logic [15:0] ev;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int bad;
    n_checks = 0;
    n_pass   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = 16'h0;
    b = 16'h0;

    vecs[0] = '{16'h3C00, 16'h4200, 16'h3555};  // 1/3 truncated
    vecs[1] = '{16'hC000, 16'h4000, 16'hBC00};  // -2/2
    vecs[2] = '{16'h4000, 16'h0000, 16'h7C00};  // x/0 -> +inf
    vecs[3] = '{16'hC000, 16'h0000, 16'hFC00};  // -x/0 -> -inf
    vecs[4] = '{16'h0000, 16'h4000, 16'h0000};  // 0/x
    vecs[5] = '{16'h0000, 16'h0000, 16'h0000};  // 0/0 -> 0
    vecs[6] = '{16'h7800, 16'h0400, 16'h7C00};  // overflow
    vecs[7] = '{16'h0400, 16'h7800, 16'h0000};  // underflow flush
    vecs[8] = '{16'h0400, 16'h3C00, 16'h0400};  // smallest normal kept

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", in_ready, 32'd1);
    check("reset_out_valid", out_valid, 32'd0);
    check("reset_c", c, 32'h0000);

    // 3.0 / 1.5 with latency measurement
    send(16'h4200, 16'h3E00, 16'h4000, 1'b1);
    measure_latency("first_op");
    drain("drain_first");

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].av, vecs[i].bv, vecs[i].ev, 1'b1);
      drain("drain_vec");
    end

    // Backpressure: result held for 20 cycles while junk in_valid is offered
    out_ready = 1'b0;
    send(16'h3C00, 16'h4200, 16'h3555, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("bp_out_valid_rises", out_valid, 32'd1);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      a = 16'h4000;
      b = 16'h0000;
      if (c !== 16'h3555 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    check("bp_hold_stable", bad, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", in_ready, 32'd1);
    check("bp_queue_popped", exp_q.size(), 32'd0);
    send(16'hC000, 16'h4000, 16'hBC00, 1'b1);
    drain("drain_after_bp");

    // Reset while BUSY with count=5; the aborted result must never appear
    send(16'h4200, 16'h3E00, 16'h0000, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 32'd1);
    check("midrst_out_valid", out_valid, 32'd0);
    check("midrst_c", c, 32'h0000);
    send(16'h4200, 16'h3E00, 16'h4000, 1'b1);
    measure_latency("after_rst");
    drain("drain_after_rst");

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
